// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file command sequencer: op codes,
// FSM states, default bank geometry and an index range helper.
package regfile_pkg;

  localparam int DEF_NREG = 8;
  localparam int DEF_DW   = 32;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_COPY  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_CP_WR,
    ST_RSP
  } state_t;

  function automatic logic idx_ok(input int idx, input int nreg);
    return idx < nreg;
  endfunction

endpackage

// File: rtl/regfile_rmux.sv
// Combinational NREG:1 read mux over the concatenated register output buses.
// Out-of-range indices read as zero.
module regfile_rmux
  import regfile_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int AW   = 3,
  parameter int DW   = DEF_DW
) (
  input  logic [NREG*DW-1:0] rdata,
  input  logic [AW-1:0]      idx,
  output logic [DW-1:0]      dout
);

  logic [DW-1:0] slot [NREG];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_slot
      assign slot[gi] = rdata[gi*DW +: DW];
    end
  endgenerate

  always_comb begin
    dout = '0;
    for (int i = 0; i < NREG; i++) begin
      if (idx == AW'(i)) dout = slot[i];
    end
  end

endmodule

// File: rtl/regfile_master.sv
// Command sequencer for the hold-register bank: issues one-hot write strobes,
// drives the shared write bus and returns READ/COPY values to the requester.
module regfile_master
  import regfile_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int AW   = 3,
  parameter int DW   = DEF_DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [AW-1:0]      cmd_dst,
  input  logic [AW-1:0]      cmd_src,
  input  logic [DW-1:0]      cmd_data,
  output logic [NREG-1:0]    reg_rw,
  output logic [DW-1:0]      reg_wdata,
  input  logic [NREG*DW-1:0] reg_rdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DW-1:0]      rsp_data,
  output logic               err
);

  state_t        state_q, state_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] src_q, src_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          err_q, err_d;
  logic          strobe;
  logic          accept;
  logic          src_ok, dst_ok;
  logic [DW-1:0] rd_val;

  regfile_rmux #(.NREG(NREG), .AW(AW), .DW(DW)) u_rmux (
    .rdata (reg_rdata),
    .idx   (src_q),
    .dout  (rd_val)
  );

  always_comb begin
    state_d    = state_q;
    dst_d      = dst_q;
    src_d      = src_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    err_d      = 1'b0;
    strobe     = 1'b0;
    reg_wdata  = wdata_q;
    cmd_ready  = (state_q == ST_IDLE);
    accept     = cmd_valid && cmd_ready;
    src_ok     = idx_ok(int'(cmd_src), NREG);
    dst_ok     = idx_ok(int'(cmd_dst), NREG);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dst_d  = cmd_dst;
          src_d  = cmd_src;
          data_d = cmd_data;
          case (cmd_op)
            OP_READ:  if (src_ok) state_d = ST_RD;    else err_d = 1'b1;
            OP_WRITE: if (dst_ok) state_d = ST_WR;    else err_d = 1'b1;
            OP_COPY:  if (src_ok && dst_ok) state_d = ST_CP_WR; else err_d = 1'b1;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_WR: begin
        strobe    = 1'b1;
        reg_wdata = data_q;
        state_d   = ST_IDLE;
      end
      ST_RD: begin
        rsp_data_d = rd_val;
        state_d    = ST_RSP;
      end
      ST_CP_WR: begin
        // Source value goes straight from the bank back onto the write bus.
        strobe     = 1'b1;
        reg_wdata  = rd_val;
        rsp_data_d = rd_val;
        state_d    = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    wdata_d = reg_wdata;
  end

  // Strobe is masked by reset so an aborted WR/CP_WR never reaches the bank.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_rw
      assign reg_rw[gi] = strobe && !rst && (dst_q == AW'(gi));
    end
  endgenerate

  assign rsp_valid = (state_q == ST_RSP);
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dst_q      <= '0;
      src_q      <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dst_q      <= dst_d;
      src_q      <= src_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

endmodule
